// File: rtl/opb_register_ppc2simulink.sv
// OPB slave exposing one byte-enabled 32-bit user register (DATA) and a 16-bit write counter (WCOUNT).
// Define OPB_REG_READBACK_EN to let OPB reads of DATA return its contents instead of zero.
module opb_register_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR    = 32'h0000_FFFF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter              C_FAMILY      = "virtex6",
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_valid
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned LANES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t               r_state;
  logic [DATA_W-1:0]    r_data;
  logic [COUNT_W-1:0]   r_wcount;
  logic                 r_xfer_ack;
  logic                 r_valid;
  logic [0:DATA_W-1]    r_dbus;

  state_t               w_state_next;
  logic [DATA_W-1:0]    w_data_next;
  logic [COUNT_W-1:0]   w_wcount_next;
  logic                 w_xfer_ack_next;
  logic                 w_valid_next;
  logic [0:DATA_W-1]    w_dbus_next;
  logic [DATA_W-1:0]    w_rd_data;
  logic [DATA_W:0]      w_base_diff;
  logic [DATA_W:0]      w_high_diff;
  logic                 w_hit;
  logic                 w_sel_wcount;
  logic                 w_unused;

  // Window check via borrow bits so a zero base never yields a constant compare
  assign w_base_diff  = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR};
  assign w_high_diff  = {1'b0, C_HIGHADDR} - {1'b0, OPB_ABus};
  assign w_hit        = OPB_select && !w_base_diff[DATA_W] && !w_high_diff[DATA_W];
  assign w_sel_wcount = w_base_diff[2];

`ifdef OPB_REG_READBACK_EN
  assign w_rd_data = w_sel_wcount ? {16'h0000, r_wcount} : r_data;
`else
  assign w_rd_data = w_sel_wcount ? {16'h0000, r_wcount} : 32'h0000_0000;
`endif

  assign w_unused = ^{OPB_seqAddr, w_base_diff[DATA_W-1:3], w_base_diff[1:0],
                      w_high_diff[DATA_W-1:0],
                      1'(C_OPB_AWIDTH == 32), 1'(C_OPB_DWIDTH == 32),
                      1'(C_FAMILY == "virtex6")};

  // Next-state and next-register values for one transaction per select assertion
  always_comb begin
    w_state_next    = r_state;
    w_data_next     = r_data;
    w_wcount_next   = r_wcount;
    w_xfer_ack_next = 1'b0;
    w_valid_next    = 1'b0;
    w_dbus_next     = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_next    = ST_ACK;
          w_xfer_ack_next = 1'b1;
          if (OPB_RNW) begin
            w_dbus_next = w_rd_data;
          end else if (!w_sel_wcount) begin
            for (int i = 0; i < int'(LANES); i++) begin
              if (OPB_BE[i]) begin
                w_data_next[DATA_W-1-8*i -: 8] = OPB_DBus[8*i +: 8];
              end
            end
            if (|OPB_BE) begin
              w_valid_next  = 1'b1;
              w_wcount_next = r_wcount + COUNT_W'(1);
            end
          end
        end
      end
      ST_ACK: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!OPB_select) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_state    <= ST_IDLE;
      r_data     <= C_RESET_VALUE;
      r_wcount   <= '0;
      r_xfer_ack <= 1'b0;
      r_valid    <= 1'b0;
      r_dbus     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_wcount   <= w_wcount_next;
      r_xfer_ack <= w_xfer_ack_next;
      r_valid    <= w_valid_next;
      r_dbus     <= w_dbus_next;
    end
  end

  assign Sl_DBus         = r_dbus;
  assign Sl_xferAck      = r_xfer_ack;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = r_data;
  assign user_data_valid = r_valid;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed self-checking bench for opb_register_ppc2simulink (honours OPB_REG_READBACK_EN).
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam logic [31:0] HIGH    = 32'h0000_FFFF;
  localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;
  localparam logic [31:0] A_DATA  = BASE;
  localparam logic [31:0] A_WCNT  = BASE + 32'd4;

  logic        OPB_Clk;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_out;
  logic        user_data_valid;

  int n_cmp = 0;
  int n_bad = 0;

  opb_register_ppc2simulink #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_RESET_VALUE(RST_VAL)
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_out(user_data_out), .user_data_valid(user_data_valid)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  task automatic tick();
    @(posedge OPB_Clk);
    #1;
  endtask

  task automatic bus_idle();
    OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0;
    OPB_DBus = '0; OPB_BE = '0; OPB_seqAddr = 1'b0;
  endtask

  // One write: capture outputs in the cycle after the hit, then drop select and return to idle
  task automatic write_tx(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output logic ack, output logic vld, output logic [31:0] uout);
    OPB_ABus = a; OPB_DBus = d; OPB_BE = be; OPB_RNW = 1'b0; OPB_select = 1'b1;
    tick();
    ack = Sl_xferAck; vld = user_data_valid; uout = user_data_out;
    bus_idle();
    tick();
    tick();
  endtask

  task automatic read_tx(input logic [31:0] a, output logic ack, output logic [31:0] d_pre,
                         output logic [31:0] d_ack, output logic [31:0] d_after);
    OPB_ABus = a; OPB_RNW = 1'b1; OPB_BE = 4'b1111; OPB_select = 1'b1;
    d_pre = Sl_DBus;
    tick();
    ack = Sl_xferAck; d_ack = Sl_DBus;
    bus_idle();
    tick();
    d_after = Sl_DBus;
    tick();
  endtask

  task automatic test_reset();
    logic ack; logic [31:0] dp, da, dn;
    bus_idle();
    OPB_Rst = 1'b1;
    tick(); tick();
    n_cmp++; if (Sl_xferAck !== 1'b0) begin n_bad++; $display("FAIL rst_ack got %b want 0", Sl_xferAck); end
    n_cmp++; if (user_data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", user_data_valid); end
    n_cmp++; if (Sl_DBus !== 32'h0) begin n_bad++; $display("FAIL rst_dbus got %h want 0", Sl_DBus); end
    n_cmp++; if (user_data_out !== RST_VAL) begin n_bad++; $display("FAIL rst_data got %h want %h", user_data_out, RST_VAL); end
    n_cmp++; if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin n_bad++;
      $display("FAIL rst_ties got %b want 000", {Sl_errAck, Sl_retry, Sl_toutSup}); end
    OPB_Rst = 1'b0;
    tick();
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rst_wcnt_ack got %b want 1", ack); end
    n_cmp++; if (da !== 32'h0) begin n_bad++; $display("FAIL rst_wcnt got %h want 0", da); end
  endtask

  task automatic test_full_write();
    logic ack, vld; logic [31:0] u, dp, da, dn;
    write_tx(A_DATA, 32'hDEAD_BEEF, 4'b1111, ack, vld, u);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL full_ack got %b want 1", ack); end
    n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL full_valid got %b want 1", vld); end
    n_cmp++; if (u !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL full_data got %h want deadbeef", u); end
    n_cmp++; if (user_data_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_len got %b want 0", user_data_valid); end
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h1) begin n_bad++; $display("FAIL full_wcnt got %h want 1", da); end
    n_cmp++; if (dn !== 32'h0) begin n_bad++; $display("FAIL full_dbus_after got %h want 0", dn); end
  endtask

  task automatic test_byte_lanes();
    logic ack, vld; logic [31:0] u, dp, da, dn;
    write_tx(A_DATA, 32'h1234_5678, 4'b0100, ack, vld, u);
    n_cmp++; if (u !== 32'hDE34_BEEF) begin n_bad++; $display("FAIL be0100_data got %h want de34beef", u); end
    n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL be0100_valid got %b want 1", vld); end
    write_tx(A_DATA, 32'hFFFF_FFFF, 4'b0000, ack, vld, u);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL be0000_ack got %b want 1", ack); end
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL be0000_valid got %b want 0", vld); end
    n_cmp++; if (u !== 32'hDE34_BEEF) begin n_bad++; $display("FAIL be0000_data got %h want de34beef", u); end
    write_tx(A_DATA, 32'h0000_00AA, 4'b0001, ack, vld, u);
    n_cmp++; if (u !== 32'hDE34_BEAA) begin n_bad++; $display("FAIL be0001_data got %h want de34beaa", u); end
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h3) begin n_bad++; $display("FAIL be_wcnt got %h want 3", da); end
  endtask

  task automatic test_wcount_write();
    logic ack, vld; logic [31:0] u, dp, da, dn;
    write_tx(A_WCNT, 32'h0000_FFFF, 4'b1111, ack, vld, u);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL wcw_ack got %b want 1", ack); end
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL wcw_valid got %b want 0", vld); end
    n_cmp++; if (u !== 32'hDE34_BEAA) begin n_bad++; $display("FAIL wcw_data got %h want de34beaa", u); end
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h3) begin n_bad++; $display("FAIL wcw_wcnt got %h want 3", da); end
  endtask

  task automatic test_held_select();
    int acks, vlds, first;
    logic ack, vld; logic [31:0] u, dp, da, dn;
    acks = 0; vlds = 0; first = -1;
    OPB_ABus = A_DATA; OPB_DBus = 32'h1122_3344; OPB_BE = 4'b1111; OPB_RNW = 1'b0; OPB_select = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (Sl_xferAck === 1'b1) begin acks++; if (first < 0) first = c; end
      if (user_data_valid === 1'b1) vlds++;
      if (c == 2) OPB_DBus = 32'h5566_7788;
    end
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL held_acks got %0d want 1", acks); end
    n_cmp++; if (vlds != 1) begin n_bad++; $display("FAIL held_valids got %0d want 1", vlds); end
    n_cmp++; if (first != 1) begin n_bad++; $display("FAIL held_first_ack got %0d want 1", first); end
    n_cmp++; if (user_data_out !== 32'h1122_3344) begin n_bad++;
      $display("FAIL held_data got %h want 11223344", user_data_out); end
    bus_idle();
    tick(); tick();
    write_tx(A_DATA, 32'hCAFE_F00D, 4'b1111, ack, vld, u);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL held_next_ack got %b want 1", ack); end
    n_cmp++; if (u !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL held_next_data got %h want cafef00d", u); end
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h5) begin n_bad++; $display("FAIL held_wcnt got %h want 5", da); end
  endtask

  task automatic test_read();
    logic ack; logic [31:0] dp, da, dn, exp;
`ifdef OPB_REG_READBACK_EN
    exp = 32'hCAFE_F00D;
`else
    exp = 32'h0000_0000;
`endif
    read_tx(A_DATA, ack, dp, da, dn);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack got %b want 1", ack); end
    n_cmp++; if (dp !== 32'h0) begin n_bad++; $display("FAIL rd_dbus_pre got %h want 0", dp); end
    n_cmp++; if (da !== exp) begin n_bad++; $display("FAIL rd_dbus_ack got %h want %h", da, exp); end
    n_cmp++; if (dn !== 32'h0) begin n_bad++; $display("FAIL rd_dbus_after got %h want 0", dn); end
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h5) begin n_bad++; $display("FAIL rd_wcnt got %h want 5", da); end
  endtask

  // Counter is preloaded near the top so the wrap costs a few writes instead of 65536
  task automatic test_wrap();
    logic ack, vld; logic [31:0] u, dp, da, dn;
    force dut.r_wcount = 16'hFFFD;
    tick();
    release dut.r_wcount;
    tick();
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h0000_FFFD) begin n_bad++; $display("FAIL wrap_pre got %h want fffd", da); end
    for (int i = 0; i < 3; i++) write_tx(A_DATA, 32'h0000_0100 + 32'(i), 4'b1111, ack, vld, u);
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h0) begin n_bad++; $display("FAIL wrap_wcnt got %h want 0", da); end
    n_cmp++; if (user_data_out !== 32'h0000_0102) begin n_bad++;
      $display("FAIL wrap_data got %h want 00000102", user_data_out); end
  endtask

  task automatic test_out_of_window();
    logic ack, vld; logic [31:0] u;
    OPB_ABus = HIGH + 32'd4; OPB_DBus = 32'h0BAD_0BAD; OPB_BE = 4'b1111; OPB_RNW = 1'b0; OPB_select = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if ({Sl_xferAck, user_data_valid} !== 2'b00 || Sl_DBus !== 32'h0) begin n_bad++;
        $display("FAIL oow_wr cyc%0d ack=%b vld=%b dbus=%h want 0", c, Sl_xferAck, user_data_valid, Sl_DBus); end
    end
    OPB_RNW = 1'b1;
    tick();
    n_cmp++; if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin n_bad++;
      $display("FAIL oow_rd ack=%b dbus=%h want 0", Sl_xferAck, Sl_DBus); end
    n_cmp++; if (user_data_out !== 32'h0000_0102) begin n_bad++;
      $display("FAIL oow_data got %h want 00000102", user_data_out); end
    write_tx(A_DATA, 32'h7777_0000, 4'b1100, ack, vld, u);
    n_cmp++; if (ack !== 1'b1 || u !== 32'h7777_0102) begin n_bad++;
      $display("FAIL oow_next ack=%b data=%h want 1/77770102", ack, u); end
  endtask

  task automatic test_reset_abort();
    logic ack; logic [31:0] dp, da, dn;
    OPB_ABus = A_DATA; OPB_DBus = 32'h0BAD_F00D; OPB_BE = 4'b1111; OPB_RNW = 1'b0; OPB_select = 1'b1;
    OPB_Rst = 1'b1;
    tick();
    n_cmp++; if (Sl_xferAck !== 1'b0 || user_data_valid !== 1'b0) begin n_bad++;
      $display("FAIL rab_pend ack=%b vld=%b want 0", Sl_xferAck, user_data_valid); end
    n_cmp++; if (user_data_out !== RST_VAL) begin n_bad++; $display("FAIL rab_pend_data got %h want %h", user_data_out, RST_VAL); end
    bus_idle();
    tick();
    OPB_Rst = 1'b0;
    tick();
    n_cmp++; if (Sl_xferAck !== 1'b0) begin n_bad++; $display("FAIL rab_late_ack got %b want 0", Sl_xferAck); end
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h0) begin n_bad++; $display("FAIL rab_wcnt got %h want 0", da); end
    OPB_ABus = A_DATA; OPB_DBus = 32'h1357_9BDF; OPB_BE = 4'b1111; OPB_RNW = 1'b0; OPB_select = 1'b1;
    tick();
    n_cmp++; if (Sl_xferAck !== 1'b1) begin n_bad++; $display("FAIL rab_ack_pre got %b want 1", Sl_xferAck); end
    OPB_Rst = 1'b1;
    tick();
    n_cmp++; if (Sl_xferAck !== 1'b0 || user_data_out !== RST_VAL) begin n_bad++;
      $display("FAIL rab_inack ack=%b data=%h want 0/%h", Sl_xferAck, user_data_out, RST_VAL); end
    OPB_DBus = 32'h600D_CAFE;
    OPB_Rst = 1'b0;
    tick();
    n_cmp++; if (Sl_xferAck !== 1'b1 || user_data_out !== 32'h600D_CAFE) begin n_bad++;
      $display("FAIL rab_release ack=%b data=%h want 1/600dcafe", Sl_xferAck, user_data_out); end
    bus_idle();
    tick(); tick();
    read_tx(A_WCNT, ack, dp, da, dn);
    n_cmp++; if (da !== 32'h1) begin n_bad++; $display("FAIL rab_wcnt_after got %h want 1", da); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    OPB_Rst = 1'b1;
    bus_idle();
    test_reset();
    test_full_write();
    test_byte_lanes();
    test_wcount_write();
    test_held_select();
    test_read();
    test_wrap();
    test_out_of_window();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
